// File: rtl/fsm_111010_tx.sv
// fsm_111010_tx: serial frame transmitter.
// A frame is the sync word 1,1,1,0,1,0 followed by the captured payload MSB
// first, optionally followed by an even-parity bit, then a one-cycle END
// marker (y=0, done=1). Define FSM_111010_TX_PARITY_EN to add the parity bit.
module fsm_111010_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    END  = 3'd4
  } state_e;

  localparam logic [5:0] SyncPattern = 6'b111010;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;

`ifdef FSM_111010_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // A new frame may start only from IDLE or the END gap cycle.
  assign accept = start && ((state_q == IDLE) || (state_q == END));

  // Next-state, counter and payload register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      state_d = SYNC;
      cnt_d   = 3'd0;
      shreg_d = data;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SYNC: begin
          if (cnt_q == 3'd5) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        DATA: begin
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
`ifdef FSM_111010_TX_PARITY_EN
            state_d = PAR;
`else
            state_d = END;
`endif
          end else begin
            cnt_d   = cnt_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end
`ifdef FSM_111010_TX_PARITY_EN
        PAR: state_d = END;
`endif
        END: state_d = IDLE;
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          shreg_d = 8'd0;
        end
      endcase
    end
  end

`ifdef FSM_111010_TX_PARITY_EN
  // Parity of the payload is latched together with it at the accept edge.
  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^data;
    end
  end
`endif

  // Output values for the state being entered, so y/busy/done are registered.
  always_comb begin
    y_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      SYNC: begin
        y_d    = SyncPattern[3'd5 - cnt_d];
        busy_d = 1'b1;
      end
      DATA: begin
        y_d    = shreg_d[7];
        busy_d = 1'b1;
      end
`ifdef FSM_111010_TX_PARITY_EN
      PAR: begin
        y_d    = parity_d;
        busy_d = 1'b1;
      end
`endif
      END: done_d = 1'b1;
      default: begin
        y_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'd0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FSM_111010_TX_PARITY_EN
  // Parity bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/fsm_111010_tx.md
FSM_111010_TX -- requirements
Module: fsm_111010_tx

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL provide port start, input, 1 bit: frame request, sampled on the rising edge of clk.
REQ-004 SHALL provide port data, input, 8 bits: payload, captured when start is accepted.
REQ-005 SHALL provide port y, output, 1 bit: serial line, registered, idle level 0.
REQ-006 SHALL provide port busy, output, 1 bit: high while a frame is on y.
REQ-007 SHALL provide port done, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-008 SHALL accept start only when busy=0; start while busy=1 is ignored and not queued.
REQ-009 SHALL capture data into an internal shift register on the accept edge; later changes to data SHALL NOT affect the frame in flight.
REQ-010 SHALL drive the frame on y starting in the cycle after the accept edge, one bit per cycle, in this order: sync 1,1,1,0,1,0; then data[7] down to data[0]; then parity, only if configured.
REQ-011 SHALL implement states IDLE, SYNC (3-bit counter 0..5), DATA (counter 0..7), PAR (only if configured) and END.
REQ-012 State transitions SHALL be:
- IDLE to SYNC on an accepted start.
- SYNC to DATA after bit 5.
- DATA to PAR, or to END when parity is not configured, after bit 7.
- PAR to END.
- END to IDLE, or to SYNC if start=1 in END.
REQ-013 Frame length SHALL be 14 bit-cycles, or 15 with parity; busy SHALL be high in exactly those cycles.
REQ-014 In END: y=0, busy=0, done=1 for exactly one cycle; start is accepted in END.
- Back-to-back frames are therefore separated by exactly one y=0 cycle.
REQ-015 SHALL hold y=0, busy=0, done=0 in IDLE.
REQ-016 Unused or illegal state encodings SHALL return to IDLE on the next edge with y=0.
REQ-017 start held high continuously SHALL produce back-to-back frames, each with fresh data captured at its own accept edge.

Reset
REQ-018 Asserting rst=0 SHALL immediately force IDLE, y=0, busy=0, done=0, and clear the counter and shift register, including mid-frame.
- The aborted frame SHALL NOT resume.
- No done pulse SHALL be generated for it.
REQ-019 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-020 Macro FSM_111010_TX_PARITY_EN:
- When defined, SHALL insert the PAR state and transmit the even parity of data (XOR of data[7:0]) as bit 15.
- When undefined, SHALL omit PAR, with a 14-bit frame and no parity logic.

Verification
REQ-021 Single frame: reset, then start=1 for 1 cycle with data=8'hA5, no parity -> y = 1,1,1,0,1,0,1,0,1,0,0,1,0,1 on cycles 1..14 after accept; busy=1 on cycles 1..14; done=1 on cycle 15 only.
REQ-022 Parity: FSM_111010_TX_PARITY_EN defined, data=8'h07 -> bit 15 = 1; data=8'h03 -> bit 15 = 0; done on cycle 16.
REQ-023 Ignored start and data stability:
- Pulse start during cycle 5 of a frame -> no extra frame.
- Change data mid-frame from 8'hFF to 8'h00 -> transmitted payload stays 8'hFF.
REQ-024 Back-to-back: start held high with data=8'h3C then 8'hC3 -> two frames separated by one y=0/done=1 cycle, payloads 3C then C3.
REQ-025 Reset mid-frame:
- Assert rst=0 asynchronously during data bit 3 -> y, busy and done go 0 before the next clk edge.
- No done pulse follows.
- The next start yields a complete, correct frame.
REQ-026 Loopback: feed y into the existing 111010 detector -> detector output y pulses once per frame, on the sixth sync bit (given no false match from the preceding idle zeros).
